// File: rtl/smc_lite_pkg.sv
// Shared types and constants for the SMC write-strobe controller.
// Pure declarations; no logic, no latency, no flow control.
// Holds the FSM state encoding, the default wait-state width and the byte-enable width.
package smc_lite_pkg;

  localparam int WS_W_DEF = 4;
  localparam int BE_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/smc_wr_strobe_ctrl_lite_if.sv
// Request/config and strobe-output bundle for the SMC write-strobe controller.
// No logic and no latency; wr_req is only honoured while busy is low.
// master drives requests and config, slave drives status and strobes.
interface smc_wr_strobe_ctrl_lite_if #(
  parameter int WS_W = smc_lite_pkg::WS_W_DEF
);
  import smc_lite_pkg::*;

  logic            wr_req;
  logic [BE_W-1:0] wr_be;
  logic [1:0]      wr_beats;
  logic [WS_W-1:0] cfg_setup;
  logic [WS_W-1:0] cfg_strobe;
  logic [WS_W-1:0] cfg_hold;

  logic            busy;
  logic            beat_done;
  logic            xfer_done;
  logic            r_full;
  logic [BE_W-1:0] n_r_we;
  logic            n_r_wr;

  modport master (
    output wr_req, wr_be, wr_beats, cfg_setup, cfg_strobe, cfg_hold,
    input  busy, beat_done, xfer_done, r_full, n_r_we, n_r_wr
  );

  modport slave (
    input  wr_req, wr_be, wr_beats, cfg_setup, cfg_strobe, cfg_hold,
    output busy, beat_done, xfer_done, r_full, n_r_we, n_r_wr
  );

endinterface

// File: rtl/smc_ws_counter.sv
// Loadable wait-state down-counter with a zero flag; saturates at zero.
// Load takes effect on the next edge; zero is decoded from the count register.
// No flow control: ld always wins over the decrement.
module smc_ws_counter #(
  parameter int WS_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld,
  input  logic [WS_W-1:0] ld_val,
  output logic            zero
);

  logic [WS_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (ld) begin
      cnt_q <= ld_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - WS_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/smc_wr_strobe_ctrl_lite.sv
// SMC write-strobe sequencer: per beat, setup / strobe / hold phases with byte enables.
// Accept-to-first-phase is one cycle; all outputs are decoded from registered state.
// No backpressure: wr_req is sampled only in IDLE and ignored while busy.
module smc_wr_strobe_ctrl_lite
  import smc_lite_pkg::*;
#(
  parameter int WS_W = WS_W_DEF
) (
  input  logic                     sys_clk,
  input  logic                     sys_reset,
  smc_wr_strobe_ctrl_lite_if.slave bus
);

  state_t          state_q, state_d;
  logic [BE_W-1:0] be_q;
  logic [1:0]      beats_q, beats_d;
  logic [WS_W-1:0] setup_q, strobe_q, hold_q;
  logic            accept;

  logic            ws_ld;
  logic [WS_W-1:0] ws_ld_val;
  logic            ws_zero;

  assign accept = (state_q == ST_IDLE) && bus.wr_req;

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q  <= ST_IDLE;
      beats_q  <= '0;
      be_q     <= '0;
      setup_q  <= '0;
      strobe_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      if (accept) begin
        be_q     <= bus.wr_be;
        setup_q  <= bus.cfg_setup;
        strobe_q <= bus.cfg_strobe;
        hold_q   <= bus.cfg_hold;
      end
    end
  end

  // The counter is loaded with (phase length - 1) on every phase entry.
  // The accept branch uses the live cfg inputs since the capture lands on the same edge.
  always_comb begin
    state_d   = state_q;
    beats_d   = beats_q;
    ws_ld     = 1'b0;
    ws_ld_val = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.wr_req) begin
          beats_d = bus.wr_beats;
          ws_ld   = 1'b1;
          if (bus.cfg_setup != '0) begin
            state_d   = ST_SETUP;
            ws_ld_val = bus.cfg_setup - WS_W'(1);
          end else begin
            state_d   = ST_STROBE;
            ws_ld_val = bus.cfg_strobe;
          end
        end
      end
      ST_SETUP: begin
        if (ws_zero) begin
          state_d   = ST_STROBE;
          ws_ld     = 1'b1;
          ws_ld_val = strobe_q;
        end
      end
      ST_STROBE: begin
        if (ws_zero) begin
          state_d   = ST_HOLD;
          ws_ld     = 1'b1;
          ws_ld_val = (hold_q == '0) ? '0 : hold_q - WS_W'(1);
        end
      end
      ST_HOLD: begin
        if (ws_zero) begin
          if (beats_q != 2'd0) begin
            beats_d = beats_q - 2'd1;
            ws_ld   = 1'b1;
            if (setup_q != '0) begin
              state_d   = ST_SETUP;
              ws_ld_val = setup_q - WS_W'(1);
            end else begin
              state_d   = ST_STROBE;
              ws_ld_val = strobe_q;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  smc_ws_counter #(.WS_W(WS_W)) u_ws_counter (
    .clk    (sys_clk),
    .rst    (sys_reset),
    .ld     (ws_ld),
    .ld_val (ws_ld_val),
    .zero   (ws_zero)
  );

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.r_full    = (state_q == ST_STROBE);
  assign bus.n_r_wr    = (state_q != ST_STROBE);
  assign bus.n_r_we    = (state_q == ST_STROBE) ? ~be_q : '1;
  assign bus.beat_done = (state_q == ST_HOLD) && ws_zero;
  assign bus.xfer_done = (state_q == ST_HOLD) && ws_zero && (beats_q == 2'd0);

endmodule

// File: tb/tb_smc_wr_strobe_ctrl_lite.sv
// Bench for smc_wr_strobe_ctrl_lite: per-transfer cycle-by-cycle expectation lists
// built from phase lengths, compared against the DUT outputs each cycle.
module tb_smc_wr_strobe_ctrl_lite;
  import smc_lite_pkg::*;

  localparam int WS_W = 4;
  localparam logic [8:0] IDLE_V = 9'b0_0_1111_1_0_0;

  logic sys_clk = 1'b0;
  logic sys_reset;
  int   checks = 0;
  int   errors = 0;

  smc_wr_strobe_ctrl_lite_if #(.WS_W(WS_W)) bus ();

  smc_wr_strobe_ctrl_lite #(.WS_W(WS_W)) dut (
    .sys_clk   (sys_clk),
    .sys_reset (sys_reset),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // {busy, r_full, n_r_we, n_r_wr, beat_done, xfer_done}
  logic [8:0] obs;
  assign obs = {bus.busy, bus.r_full, bus.n_r_we, bus.n_r_wr, bus.beat_done, bus.xfer_done};

  logic [8:0] exp_q[$];

  task automatic build_model(input logic [3:0] be, input logic [1:0] beats,
                             input int s, input int st, input int h);
    int hl;
    exp_q.delete();
    hl = (h == 0) ? 1 : h;
    for (int b = 0; b <= int'(beats); b++) begin
      for (int i = 0; i < s; i++)
        exp_q.push_back({1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0});
      for (int i = 0; i <= st; i++)
        exp_q.push_back({1'b1, 1'b1, ~be, 1'b0, 1'b0, 1'b0});
      for (int i = 0; i < hl; i++)
        exp_q.push_back({1'b1, 1'b0, 4'hF, 1'b1, (i == hl - 1), (i == hl - 1) && (b == int'(beats))});
    end
  endtask

  // scramble: 0 none, 1 directed (wr_be=F, cfg_strobe=7, wr_req toggling), 2 random
  task automatic run_xfer(input string name, input logic [3:0] be, input logic [1:0] beats,
                          input int s, input int st, input int h,
                          input int scramble, input bit keep_req, input int reset_at);
    build_model(be, beats, s, st, h);
    bus.wr_req     = 1'b1;
    bus.wr_be      = be;
    bus.wr_beats   = beats;
    bus.cfg_setup  = WS_W'(s);
    bus.cfg_strobe = WS_W'(st);
    bus.cfg_hold   = WS_W'(h);
    @(posedge sys_clk); #1;
    for (int c = 0; c < exp_q.size(); c++) begin
      if (!keep_req) bus.wr_req = 1'b0;
      if (scramble == 1) begin
        bus.wr_req     = c[0];
        bus.wr_be      = 4'hF;
        bus.cfg_strobe = WS_W'(7);
      end else if (scramble == 2) begin
        bus.wr_req     = 1'($urandom);
        bus.wr_be      = 4'($urandom);
        bus.wr_beats   = 2'($urandom);
        bus.cfg_setup  = WS_W'($urandom);
        bus.cfg_strobe = WS_W'($urandom);
        bus.cfg_hold   = WS_W'($urandom);
      end
      checks++;
      if (obs !== exp_q[c]) begin
        errors++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, c + 1, obs, exp_q[c]);
      end
      if (c + 1 == reset_at) begin
        bus.wr_req = 1'b0;
        sys_reset  = 1'b1;
        @(posedge sys_clk); #1;
        sys_reset = 1'b0;
        checks++;
        if (obs !== IDLE_V) begin
          errors++;
          $display("FAIL %s after_reset: got %b expected %b", name, obs, IDLE_V);
        end
        return;
      end
      @(posedge sys_clk); #1;
    end
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL %s idle_after: got %b expected %b", name, obs, IDLE_V);
    end
    if (!keep_req) bus.wr_req = 1'b0;
  endtask

  task automatic test_reset();
    sys_reset      = 1'b1;
    bus.wr_req     = 1'b0;
    bus.wr_be      = '0;
    bus.wr_beats   = '0;
    bus.cfg_setup  = '0;
    bus.cfg_strobe = '0;
    bus.cfg_hold   = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", obs, IDLE_V);
    end
    sys_reset = 1'b0;
    @(posedge sys_clk); #1;
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL idle_no_req: got %b expected %b", obs, IDLE_V);
    end
  endtask

  task automatic test_single_beat();
    run_xfer("single_beat", 4'b0101, 2'd0, 2, 3, 1, 0, 1'b0, -1);
  endtask

  task automatic test_zero_waits();
    run_xfer("zero_waits", 4'hC, 2'd3, 0, 0, 0, 0, 1'b0, -1);
  endtask

  task automatic test_reset_mid_strobe();
    run_xfer("reset_mid_strobe", 4'b0101, 2'd0, 2, 3, 1, 0, 1'b0, 4);
    @(posedge sys_clk); #1;
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL reset_recover_idle: got %b expected %b", obs, IDLE_V);
    end
  endtask

  task automatic test_change_while_busy();
    run_xfer("change_busy", 4'b0010, 2'd1, 1, 2, 2, 1, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    run_xfer("b2b_first", 4'h9, 2'd0, 0, 1, 0, 0, 1'b1, -1);
    run_xfer("b2b_second", 4'h6, 2'd1, 0, 0, 1, 0, 1'b0, -1);
  endtask

  task automatic test_max_wait();
    run_xfer("max_wait", 4'hA, 2'd0, 1, 15, 2, 0, 1'b0, -1);
    run_xfer("max_all", 4'h3, 2'd1, 15, 15, 15, 0, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      int s, st, h;
      s  = $urandom_range(0, 4);
      st = ($urandom_range(0, 5) == 0) ? 15 : $urandom_range(0, 5);
      h  = $urandom_range(0, 3);
      run_xfer($sformatf("random_%0d", n), 4'($urandom), 2'($urandom), s, st, h,
               ($urandom_range(0, 1) == 1) ? 2 : 0, 1'b0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_zero_waits();
    test_reset_mid_strobe();
    test_change_while_busy();
    test_back_to_back();
    test_max_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/smc_wr_strobe_ctrl_lite.md
SMC_WR_STROBE_CTRL_LITE -- requirements
Module: smc_wr_strobe_ctrl_lite

Interface
REQ-001 Parameter WS_W, default 4: width of each wait-state configuration field and counter.
REQ-002 sys_clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 sys_reset  in  1  reset, synchronous and active-high.
REQ-004 wr_req  in  1  request to start a write transfer; sampled only in IDLE.
REQ-005 wr_be  in  4  byte enables, active high; captured on accept.
REQ-006 wr_beats  in  2  number of beats minus 1 (1..4 beats); captured on accept.
REQ-007 cfg_setup  in  WS_W  setup cycles before strobe (0 allowed); captured on accept.
REQ-008 cfg_strobe  in  WS_W  strobe length minus 1; captured on accept.
REQ-009 cfg_hold  in  WS_W  hold cycles after strobe; captured on accept.
REQ-010 busy  out  1  high from the cycle after accept until return to IDLE.
REQ-011 beat_done  out  1  one-cycle pulse in the last cycle of each beat.
REQ-012 xfer_done  out  1  one-cycle pulse in the last cycle of the final beat.
REQ-013 r_full  out  1  full-cycle write qualifier to the write-enable gating stage.
REQ-014 n_r_we  out  4  active-low byte write enables.
REQ-015 n_r_wr  out  1  active-low write strobe.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, STROBE and HOLD.
REQ-017 In IDLE with wr_req=1, the block SHALL capture wr_be, wr_beats and cfg_* and go to SETUP if cfg_setup!=0, else to STROBE.
REQ-018 SETUP SHALL last exactly setup_q cycles with r_full=0, n_r_we=4'hF, n_r_wr=1.
REQ-019 STROBE SHALL last exactly strobe_q+1 cycles with r_full=1, n_r_we=~be_q, n_r_wr=0.
REQ-020 HOLD SHALL last max(hold_q,1) cycles with strobes inactive, guaranteeing at least one deasserted cycle between beats and transfers.
REQ-021 On the last HOLD cycle, beat_done SHALL pulse; if beats remain, the beat count decrements and the FSM re-enters SETUP (or STROBE if setup_q=0), else xfer_done pulses and the FSM returns to IDLE.
REQ-022 All outputs SHALL be registered or decoded only from registered state, with no combinational path from any input.
REQ-023 wr_req and cfg_*/wr_be changes while busy=1 SHALL be ignored; captured values hold for the whole transfer.
REQ-024 A wr_req held high SHALL be accepted in the first IDLE cycle after xfer_done, giving at least one IDLE cycle between transfers.
REQ-025 With wr_be=4'h0, the sequence SHALL run normally with n_r_we=4'hF and n_r_wr still pulsing.
REQ-026 Wait-state counters SHALL be WS_W-bit loadable down-counters that never wrap; cfg_strobe at all-ones yields 2^WS_W strobe cycles.

Reset
REQ-027 A sys_reset edge SHALL force IDLE from any state, including mid-strobe.
REQ-028 Outputs after that edge SHALL be: busy=0, beat_done=0, xfer_done=0, r_full=0, n_r_we=4'hF, n_r_wr=1.
REQ-029 On the reset edge, all captured registers and counters SHALL be cleared to 0.

Structure
REQ-030 A shared package smc_lite_pkg SHALL hold the state enumeration, the WS_W default and the byte-enable width constant (4).
REQ-031 One sub-module, smc_ws_counter (loadable down-counter with zero flag), SHALL be instantiated for the wait-state count.
REQ-032 The beat counter SHALL be a local 2-bit register.

Verification
REQ-033 Single beat: wr_be=4'b0101, setup=2, strobe=3, hold=1, beats=0, req at cycle 0 -> SETUP cycles 1-2; r_full=1, n_r_we=4'b1010, n_r_wr=0 cycles 3-6; HOLD cycle 7 with beat_done=xfer_done=1; IDLE cycle 8.
REQ-034 Zero waits: setup=0, strobe=0, hold=0, beats=3 -> four 1-cycle strobes separated by exactly one inactive HOLD cycle; 4 beat_done pulses and 1 xfer_done.
REQ-035 Reset mid-strobe: assert sys_reset in cycle 4 of REQ-033 -> cycle 5 shows IDLE, r_full=0, n_r_we=4'hF, n_r_wr=1, busy=0, and no xfer_done.
REQ-036 Change while busy: toggle wr_req, wr_be=4'hF and cfg_strobe=7 during a transfer -> the strobe length and n_r_we stay at the captured values.
REQ-037 Back-to-back: wr_req held high across two transfers -> second accept in the cycle after xfer_done, and n_r_wr high for at least 2 cycles between strobes.
REQ-038 Max wait: cfg_strobe=4'hF -> exactly 16 strobe cycles, with no counter wrap.
